// File: rtl/execute_muldiv_if.sv
// Handshake and result bus between the pipeline controller and the mul/div unit.
interface execute_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Controller side: issues requests, observes status and HI/LO.
  modport master (
    output start, op, Read_data_1, Read_data_2,
    input  busy, done, div_by_zero, hi, lo
  );

  // Unit side.
  modport slave (
    input  start, op, Read_data_1, Read_data_2,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/execute_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Shift-add multiplier and restoring divider on a shared 2*WIDTH accumulator;
// signed operations run on magnitudes and fix up signs in a final cycle.
// Optional: define EXECUTE_MULDIV_FAST_MUL_EN for a single-cycle multiplier
// (IDLE -> FIX directly for MULT/MULTU; dividers are unaffected).
module execute_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input logic             clock,
  input logic             reset,
  execute_muldiv_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned DW    = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [DW-1:0]    acc;      // mul: {partial product, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0] opb;      // multiplicand or divisor magnitude
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_main; // negate product / quotient
  logic             neg_rem;  // remainder follows dividend sign
  logic             dz;

  // Operand sign extraction and magnitudes for the request being presented.
  logic             is_signed_c;
  logic             sa_c;
  logic             sb_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;

  always_comb begin
    is_signed_c = ~bus.op[0];
    sa_c        = is_signed_c & bus.Read_data_1[WIDTH-1];
    sb_c        = is_signed_c & bus.Read_data_2[WIDTH-1];
    mag_a_c     = sa_c ? (-bus.Read_data_1) : bus.Read_data_1;
    mag_b_c     = sb_c ? (-bus.Read_data_2) : bus.Read_data_2;
  end

`ifdef EXECUTE_MULDIV_FAST_MUL_EN
  logic [DW-1:0] fast_prod_c;

  // Single-cycle magnitude product.
  always_comb begin
    fast_prod_c = DW'(mag_a_c) * DW'(mag_b_c);
  end
`endif

  // One shift-add or restoring-divide iteration on the accumulator.
  logic [WIDTH:0]  mul_sum_c;
  logic [WIDTH:0]  rem_sh_c;
  logic [WIDTH:0]  diff_c;
  logic [DW-1:0]   iter_next_c;

  always_comb begin
    mul_sum_c   = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    rem_sh_c    = acc[DW-1:WIDTH-1];
    diff_c      = rem_sh_c - {1'b0, opb};
    iter_next_c = {mul_sum_c, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!diff_c[WIDTH]) begin
        iter_next_c = {diff_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        iter_next_c = {rem_sh_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up of the finished magnitude result.
  logic [DW-1:0]    prod_fix_c;
  logic [WIDTH-1:0] quot_fix_c;
  logic [WIDTH-1:0] rem_fix_c;
  logic [WIDTH-1:0] hi_fix_c;
  logic [WIDTH-1:0] lo_fix_c;

  always_comb begin
    prod_fix_c = neg_main ? (-acc) : acc;
    quot_fix_c = neg_main ? (-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix_c  = neg_rem ? (-acc[DW-1:WIDTH]) : acc[DW-1:WIDTH];
    hi_fix_c   = prod_fix_c[DW-1:WIDTH];
    lo_fix_c   = prod_fix_c[WIDTH-1:0];
    if (is_div) begin
      // With a zero divisor the remainder is the dividend magnitude, so the
      // remainder sign rule restores the original rs exactly.
      hi_fix_c = rem_fix_c;
      lo_fix_c = dz ? '1 : quot_fix_c;
    end
  end

  // Control FSM, datapath registers and HI/LO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      acc             <= '0;
      opb             <= '0;
      cnt             <= '0;
      is_div          <= 1'b0;
      neg_main        <= 1'b0;
      neg_rem         <= 1'b0;
      dz              <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
    end else begin
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MTHI: bus.hi <= bus.Read_data_1;
              OP_MTLO: bus.lo <= bus.Read_data_1;
              OP_MULT, OP_MULTU: begin
                opb      <= mag_a_c;
                is_div   <= 1'b0;
                neg_main <= sa_c ^ sb_c;
                neg_rem  <= 1'b0;
                dz       <= 1'b0;
                cnt      <= '0;
                bus.busy <= 1'b1;
`ifdef EXECUTE_MULDIV_FAST_MUL_EN
                acc      <= fast_prod_c;
                state    <= S_FIX;
`else
                acc      <= {WIDTH'(0), mag_b_c};
                state    <= S_RUN;
`endif
              end
              OP_DIV, OP_DIVU: begin
                opb      <= mag_b_c;
                acc      <= {WIDTH'(0), mag_a_c};
                is_div   <= 1'b1;
                neg_main <= sa_c ^ sb_c;
                neg_rem  <= sa_c;
                dz       <= (bus.Read_data_2 == '0);
                cnt      <= '0;
                bus.busy <= 1'b1;
                state    <= S_RUN;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          acc <= iter_next_c;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          bus.hi          <= hi_fix_c;
          bus.lo          <= lo_fix_c;
          bus.done        <= 1'b1;
          bus.div_by_zero <= is_div & dz;
          bus.busy        <= 1'b0;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv at WIDTH=32.
module tb_execute_muldiv;

  localparam int unsigned W = 32;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam int DIV_LAT = W + 1;
`ifdef EXECUTE_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic prev_done = 1'b0;

  execute_muldiv_if #(.WIDTH(W)) bus ();

  execute_muldiv #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic, independent of the iterative hardware algorithm.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa;
    longint      sbv;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.dz = 1'b0;
    case (op)
      OP_MULT: begin
        p = 64'(sa * sbv);
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      OP_DIV: begin
        if (b == '0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else begin
          q = sa / sbv; r = sa % sbv;
          e.hi = 32'(r); e.lo = 32'(q);
        end
      end
      default: begin
        if (b == '0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else begin
          e.hi = a % b; e.lo = a / b;
        end
      end
    endcase
    return e;
  endfunction

  // Compare HI/LO against the scoreboard whenever the unit reports done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (prev_done) check_eq("done_width", 1, 0);
        if (sb.size() == 0) begin
          check_eq("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("hi", bus.hi, e.hi);
          check_eq("lo", bus.lo, e.lo);
          check_eq("div_by_zero", bus.div_by_zero, e.dz);
        end
      end else if (bus.div_by_zero) begin
        check_eq("dz_without_done", 1, 0);
      end
      prev_done <= bus.done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  // Issue one mul/div (entered and left #1 after a rising edge).
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e, input int lat, input bit poke);
    int n;
    int busy_cyc;
    bus.start = 1'b1;
    bus.op = op;
    bus.Read_data_1 = a;
    bus.Read_data_2 = b;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 3'($urandom);
    bus.Read_data_1 = $urandom;
    bus.Read_data_2 = $urandom;
    n = 0;
    busy_cyc = 0;
    while (!bus.done && n < 80) begin
      if (bus.busy) busy_cyc++;
      if (poke && n == 3) begin
        bus.start = 1'b1;
        bus.op = OP_MTHI;
        bus.Read_data_1 = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check_eq("latency", n, lat);
    check_eq("busy_cycles", busy_cyc, lat);
    check_eq("busy_in_done", bus.busy, 0);
  endtask

  task automatic do_dir(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dz = edz;
    do_op(op, a, b, e, op[1] ? DIV_LAT : MUL_LAT, 1'b0);
  endtask

  // Single-cycle idle-time requests (MTHI/MTLO/no-op).
  task automatic do_move(input logic [2:0] op, input logic [W-1:0] a);
    bus.start = 1'b1;
    bus.op = op;
    bus.Read_data_1 = a;
    bus.Read_data_2 = $urandom;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [2:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = '0;
    bus.Read_data_1 = '0;
    bus.Read_data_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hi", bus.hi, 0);
    check_eq("rst_lo", bus.lo, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_dz", bus.div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_dir(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    do_dir(OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

    do_move(OP_MTLO, 32'hCAFE_F00D);
    check_eq("mtlo_lo", bus.lo, 32'hCAFE_F00D);
    check_eq("mtlo_hi", bus.hi, 32'hFFFF_FFFF);
    check_eq("mtlo_done", bus.done, 0);
    check_eq("mtlo_busy", bus.busy, 0);

    do_move(3'b110, 32'h1111_2222);
    check_eq("noop_hi", bus.hi, 32'hFFFF_FFFF);
    check_eq("noop_lo", bus.lo, 32'hCAFE_F00D);
    check_eq("noop_busy", bus.busy, 0);

    do_move(OP_MTHI, 32'h1234_5678);
    check_eq("mthi_hi", bus.hi, 32'h1234_5678);
    check_eq("mthi_busy", bus.busy, 0);

    do_dir(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_dir(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    do_dir(OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    do_dir(OP_DIVU, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    do_dir(OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

    // MTHI presented while the multiplier is busy must be dropped.
    e = model(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    do_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, e, MUL_LAT, 1'b1);
    check_eq("poke_hi_kept", bus.hi, e.hi);

    for (int i = 0; i < 12; i++) begin
      rop = 3'(i % 4);
      ra = $urandom;
      rb = ((i % 5) == 4) ? 32'd0 : 32'($urandom);
      if ((i % 3) == 1) rb = rb >> 20;
      e = model(rop, ra, rb);
      do_op(rop, ra, rb, e, rop[1] ? DIV_LAT : MUL_LAT, 1'b0);
    end

    // Abort a divide with an asynchronous reset.
    bus.start = 1'b1;
    bus.op = OP_DIV;
    bus.Read_data_1 = 32'd1000;
    bus.Read_data_2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_hi", bus.hi, 0);
    check_eq("abort_lo", bus.lo, 0);
    check_eq("abort_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("post_abort_hi", bus.hi, 0);
    check_eq("post_abort_lo", bus.lo, 0);
    check_eq("post_abort_busy", bus.busy, 0);

    do_dir(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

    repeat (2) @(posedge clk);
    check_eq("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit that sits beside the single-cycle execute ALU in the MIPS datapath.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO with architectural HI/LO registers.
- Uses an iterative shift-add multiplier and a restoring divider. A start/busy/done handshake lets the controller stall the pipeline while an operation runs.
- Register operands use the same naming as the execute stage: Read_data_1 is rs, Read_data_2 is rt.

Parameters:
- WIDTH, 32, operand/HI/LO width; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not to be overridden.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- Read_data_1  input  WIDTH  rs operand: multiplicand / dividend / MTHI-MTLO source.
- Read_data_2  input  WIDTH  rt operand: multiplier / divisor.
- busy  output  1  high while a mul/div is in progress.
- done  output  1  one-cycle pulse when HI/LO are updated by a mul/div.
- div_by_zero  output  1  one-cycle pulse coincident with done, for DIV/DIVU with rt == 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; counter and datapath cleared.
- Reset asserted mid-operation aborts the operation; no partial result reaches hi/lo.
- States are IDLE, RUN, FIX.
- IDLE:
  - start with op MTHI/MTLO: hi/lo written from Read_data_1 at that edge; busy stays 0; done stays 0.
  - start with op 11x: ignored.
  - start with mul/div: latch operand magnitudes; signed ops take the absolute value and record the result signs.
  - Next state RUN, busy=1, counter=0.
- RUN, one iteration per cycle for WIDTH cycles:
  - MUL: if multiplier LSB is set, add multiplicand to the upper accumulator; then shift the 2*WIDTH accumulator right by 1.
  - DIV: shift {rem,quot} left by 1; trial-subtract the divisor; if the result is non-negative, keep it and set quotient LSB.
  - After counter == WIDTH-1, next state is FIX.
- FIX, one cycle:
  - Apply signs. Signed product is negated if the operand signs differ. Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Write hi/lo, pulse done, clear busy, return to IDLE.
- Latency:
  - Accept at edge E0 sets busy=1 after E0.
  - hi/lo update and done=1 occur after edge E0+WIDTH+1.
  - busy is 0 in the done cycle. A new start may be accepted in that same done cycle.
- start while busy=1 is ignored, whatever op is presented. No queuing.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product.
  - DIV/DIVU: lo = quotient, hi = remainder, truncation toward zero.
  - Most-negative / -1: lo = 1<<(WIDTH-1), hi = 0 (wraps, no trap).
- Divide by zero: full latency is still taken; hi = Read_data_1 as latched, lo = all ones; div_by_zero pulses with done.
- Operands are latched at accept; later changes on Read_data_1/2 have no effect.
- hi/lo hold their values at all other times.

Optional Feature:
- Macro: EXECUTE_MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle combinational product; the state goes IDLE -> FIX directly.
  - busy is high for one cycle; done follows after edge E0+1.
  - DIV/DIVU are unchanged.
- Undefined: iterative multiplier as described above.

Test Plan:
- MULTU, WIDTH=32, rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 33 edges: hi=0xFFFFFFFE, lo=0x00000001; done high exactly one cycle; busy high 33 cycles.
- MULT rs=-3 (0xFFFFFFFD), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - With EXECUTE_MULDIV_FAST_MUL_EN: same result with done after edge E0+1.
- DIV cases:
  - DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU rs=100, rt=7 -> lo=14, hi=2.
- DIVU rs=0x1234, rt=0 -> after 33 edges: hi=0x1234, lo=0xFFFFFFFF; div_by_zero and done pulse together.
- Handshake:
  - start MULTU, then re-assert start with MTHI while busy -> hi unaffected by MTHI; final hi/lo come from MULTU.
  - MTLO rs=0xCAFEF00D while idle -> lo=0xCAFEF00D next cycle; done stays 0.
- Reset mid-operation: pulse reset low 10 cycles into a DIV -> hi=lo=0, busy=0 immediately (asynchronous); no done afterwards; a new MULT then completes correctly.
